// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the analog-mux scan controller: channel count,
// select-bit ordering and FSM state encodings.
package mux_scan_ctrl_pkg;

   localparam int CH_N = 8;
   localparam int CH_W = 3;

   // Select pins map to the channel index with s0 as the MSB.
   localparam int SEL_S0_BIT = 2;
   localparam int SEL_S1_BIT = 1;
   localparam int SEL_S2_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mux_scan_ctrl_finder.sv
// Combinational search for the lowest enabled channel strictly above the
// current one, or the lowest enabled channel overall when from_start_i is set.
module next_chan_finder
   import mux_scan_ctrl_pkg::*;
(
   input  logic [CH_N-1:0] mask_i,
   input  logic [CH_W-1:0] cur_i,
   input  logic            from_start_i,
   output logic [CH_W-1:0] next_o,
   output logic            found_o
);

   logic [CH_N-1:0] above_mask;
   logic [CH_N-1:0] eligible;

   // Bits strictly above cur_i; the shift wraps to zero for the top channel.
   assign above_mask = ~((CH_N'(2) << cur_i) - CH_N'(1));
   assign eligible   = from_start_i ? mask_i : (mask_i & above_mask);

   always_comb begin
      next_o  = '0;
      found_o = 1'b0;
      for (int k = CH_N - 1; k >= 0; k--) begin
         if (eligible[k]) begin
            next_o  = CH_W'(k);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps an external 8:1 mux over the enabled channels, waiting dwell+1
// settle cycles per channel before capturing Y into the sample vector.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               continuous,
   input  logic [CH_N-1:0]    mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               Y,
   output logic               s0,
   output logic               s1,
   output logic               s2,
   output logic               busy,
   output logic               done,
   output logic [CH_N-1:0]    sample,
   output logic               sample_valid
);

   state_t             state_q;
   logic [CH_W-1:0]    ch_q;
   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [CH_N-1:0]    mask_q;
   logic [CH_N-1:0]    shadow_q;
   logic [CH_N-1:0]    sample_q;
   logic               busy_q;
   logic               done_q;
   logic               valid_q;
   logic               start_q;
   logic               start_d;

   logic               launch;
   logic [CH_N-1:0]    merged;
   logic [CH_N-1:0]    find_mask;
   logic               find_from_start;
   logic [CH_W-1:0]    find_next;
   logic               find_found;

   // start is registered once so the first select lands one edge after it is seen.
   assign start_d = (state_q == ST_IDLE) && start && !start_q;
   assign launch  = ((state_q == ST_IDLE) && start_q) ||
                    ((state_q == ST_DONE) && continuous);

   assign find_from_start = (state_q != ST_SAMPLE);
   assign find_mask       = find_from_start ? mask : mask_q;

   next_chan_finder u_finder (
      .mask_i       (find_mask),
      .cur_i        (ch_q),
      .from_start_i (find_from_start),
      .next_o       (find_next),
      .found_o      (find_found)
   );

   always_comb begin
      merged       = shadow_q;
      merged[ch_q] = Y;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ch_q     <= '0;
         cnt_q    <= '0;
         dwell_q  <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         sample_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         start_q <= start_d;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         if (launch) begin
            mask_q   <= mask;
            dwell_q  <= dwell;
            shadow_q <= '0;
            if (find_found) begin
               ch_q    <= find_next;
               cnt_q   <= dwell;
               busy_q  <= 1'b1;
               state_q <= ST_SETTLE;
            end else begin
               sample_q <= '0;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               valid_q  <= 1'b1;
               state_q  <= ST_DONE;
            end
         end else begin
            case (state_q)
               ST_SETTLE: begin
                  if (cnt_q == '0) state_q <= ST_SAMPLE;
                  else             cnt_q   <= cnt_q - DWELL_W'(1);
               end
               ST_SAMPLE: begin
                  shadow_q <= merged;
                  if (find_found) begin
                     ch_q    <= find_next;
                     cnt_q   <= dwell_q;
                     state_q <= ST_SETTLE;
                  end else begin
                     sample_q <= merged;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     valid_q  <= 1'b1;
                     state_q  <= ST_DONE;
                  end
               end
               ST_DONE:  state_q <= ST_IDLE;
               default:  state_q <= state_q;
            endcase
         end
      end
   end

   assign s0           = ch_q[SEL_S0_BIT];
   assign s1           = ch_q[SEL_S1_BIT];
   assign s2           = ch_q[SEL_S2_BIT];
   assign busy         = busy_q;
   assign done         = done_q;
   assign sample_valid = valid_q;
   assign sample       = sample_q;

endmodule
